// File: rtl/exu_mul_wb.sv
// exu_mul_wb: writeback buffer for a fixed 3-cycle, non-stallable multiplier.
// A shadow pipeline carries (valid, rd, rob_id) alongside the multiplier.
// Stage-3 results are pushed into a small FIFO whose head drives the
// writeback port. A credit counter limits in-flight plus buffered ops to
// DEPTH, so the FIFO can never overflow.
//
// Handshake: issue is accepted on issue_valid & issue_ready (issue_ready
// already includes ~flush); writeback pops on wb_valid & wb_ready; while
// wb_valid is high and wb_ready is low the wb_* outputs hold stable.
module exu_mul_wb #(
    parameter int DATA_WIDTH     = 64,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ROB_ID_WIDTH   = 6,
    parameter int DEPTH          = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    output logic                      issue_ready,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic [ROB_ID_WIDTH-1:0]   issue_rob_id,
    input  logic                      flush,
    input  logic [DATA_WIDTH-1:0]     mul_result,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic [ROB_ID_WIDTH-1:0]   wb_rob_id,
    output logic [DATA_WIDTH-1:0]     wb_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // Shadow pipeline: index 0 = stage 1, index 2 = stage 3.
    logic [2:0]                s_valid_q, s_valid_d;
    logic [REG_ADDR_WIDTH-1:0] s_rd_q  [3];
    logic [REG_ADDR_WIDTH-1:0] s_rd_d  [3];
    logic [ROB_ID_WIDTH-1:0]   s_rob_q [3];
    logic [ROB_ID_WIDTH-1:0]   s_rob_d [3];

    // Result FIFO storage and bookkeeping.
    logic [REG_ADDR_WIDTH-1:0] fifo_rd_q   [DEPTH];
    logic [REG_ADDR_WIDTH-1:0] fifo_rd_d   [DEPTH];
    logic [ROB_ID_WIDTH-1:0]   fifo_rob_q  [DEPTH];
    logic [ROB_ID_WIDTH-1:0]   fifo_rob_d  [DEPTH];
    logic [DATA_WIDTH-1:0]     fifo_data_q [DEPTH];
    logic [DATA_WIDTH-1:0]     fifo_data_d [DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          fifo_cnt_q, fifo_cnt_d;
    logic                      wb_valid_q, wb_valid_d;

    // Credit counter covers ops in the multiplier plus ops in the FIFO.
    logic [CNT_W-1:0]          credit_q, credit_d;

    logic accept;
    logic push;
    logic pop;

    // Handshake decode.
    always_comb begin
        issue_ready = (credit_q < DEPTH_CNT) & ~flush;
        accept      = issue_valid & issue_ready;
        push        = s_valid_q[2] & ~flush;
        pop         = wb_valid_q & wb_ready;
    end

    // Shadow pipeline advance; flush kills every stage.
    always_comb begin
        s_valid_d  = {s_valid_q[1:0], accept};
        s_rd_d[0]  = issue_rd;
        s_rd_d[1]  = s_rd_q[0];
        s_rd_d[2]  = s_rd_q[1];
        s_rob_d[0] = issue_rob_id;
        s_rob_d[1] = s_rob_q[0];
        s_rob_d[2] = s_rob_q[1];
        if (flush) begin
            s_valid_d = '0;
        end
    end

    // FIFO write/read pointers, occupancy and registered head-valid.
    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_rob_d  = fifo_rob_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        if (push) begin
            fifo_rd_d[wr_ptr_q]   = s_rd_q[2];
            fifo_rob_d[wr_ptr_q]  = s_rob_q[2];
            fifo_data_d[wr_ptr_q] = mul_result;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
        end
        wb_valid_d = (fifo_cnt_d != '0);
    end

    // Credit accounting: +1 on accepted issue, -1 on pop, cleared by flush.
    always_comb begin
        case ({accept, pop})
            2'b10:   credit_d = credit_q + 1'b1;
            2'b01:   credit_d = credit_q - 1'b1;
            default: credit_d = credit_q;
        endcase
        if (flush) begin
            credit_d = '0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_valid_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            wb_valid_q <= 1'b0;
            credit_q   <= '0;
            for (int i = 0; i < 3; i++) begin
                s_rd_q[i]  <= '0;
                s_rob_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                fifo_rd_q[i]   <= '0;
                fifo_rob_q[i]  <= '0;
                fifo_data_q[i] <= '0;
            end
        end else begin
            s_valid_q   <= s_valid_d;
            s_rd_q      <= s_rd_d;
            s_rob_q     <= s_rob_d;
            fifo_rd_q   <= fifo_rd_d;
            fifo_rob_q  <= fifo_rob_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            wb_valid_q  <= wb_valid_d;
            credit_q    <= credit_d;
        end
    end

    // Writeback port comes straight from the FIFO head registers.
    always_comb begin
        wb_valid  = wb_valid_q;
        wb_rd     = fifo_rd_q[rd_ptr_q];
        wb_rob_id = fifo_rob_q[rd_ptr_q];
        wb_data   = fifo_data_q[rd_ptr_q];
    end

    // The credit limit makes a push into a full FIFO unreachable.
    push_into_full_a : assert property (@(posedge clk) disable iff (rst)
        !(push && (fifo_cnt_q == DEPTH_CNT)));

endmodule

// File: tb/tb_exu_mul_wb.sv
// Directed bench for exu_mul_wb: single op, back-to-back with stall,
// simultaneous pop/issue at full credit, flush, and reset mid-drain.
module tb_exu_mul_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rd;
  logic [5:0]  issue_rob_id;
  logic        flush;
  logic [63:0] mul_result;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [5:0]  wb_rob_id;
  logic [63:0] wb_data;

  int total = 0;
  int bad   = 0;

  // Multiplier model: the product value presented with an issue appears
  // on mul_result three cycles later.
  logic [63:0] issue_val;
  logic [63:0] p1 = '0;
  logic [63:0] p2 = '0;
  logic [63:0] p3 = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    p1 <= issue_val;
    p2 <= p1;
    p3 <= p2;
  end
  assign mul_result = p3;

  exu_mul_wb dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_rd     (issue_rd),
    .issue_rob_id (issue_rob_id),
    .flush        (flush),
    .mul_result   (mul_result),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_rd        (wb_rd),
    .wb_rob_id    (wb_rob_id),
    .wb_data      (wb_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [4:0] rd, input logic [5:0] rob, input logic [63:0] val);
    issue_valid  = v;
    issue_rd     = rd;
    issue_rob_id = rob;
    issue_val    = val;
  endtask

  task automatic idle();
    issue(1'b0, 5'd0, 6'd0, 64'd0);
  endtask

  task automatic check_wb(input string tag, input logic [4:0] rd, input logic [5:0] rob, input logic [63:0] data);
    check({tag, "_valid"}, {63'd0, wb_valid}, 64'd1);
    check({tag, "_rd"},    {59'd0, wb_rd},    {59'd0, rd});
    check({tag, "_rob"},   {58'd0, wb_rob_id}, {58'd0, rob});
    check({tag, "_data"},  wb_data,           data);
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    flush = 1'b0;
    wb_ready = 1'b1;
    idle();
    repeat (2) tick();
    check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    check("rst_wb_rd",    {59'd0, wb_rd},    64'd0);
    check("rst_wb_rob",   {58'd0, wb_rob_id}, 64'd0);
    check("rst_wb_data",  wb_data,           64'd0);
    rst = 1'b0;
    #1;
    check("rst_issue_ready", {63'd0, issue_ready}, 64'd1);

    // Single op: issue cycle 0, writeback in cycle 4 for one cycle
    tick();
    issue(1'b1, 5'd5, 6'd3, 64'h1234);
    #1;
    check("sop_ready", {63'd0, issue_ready}, 64'd1);
    tick();
    idle();
    #1;
    check("sop_c1_wbv", {63'd0, wb_valid}, 64'd0);
    tick();
    tick();
    check("sop_c3_wbv", {63'd0, wb_valid}, 64'd0);
    tick();
    check_wb("sop_c4", 5'd5, 6'd3, 64'h1234);
    tick();
    check("sop_c5_wbv", {63'd0, wb_valid}, 64'd0);

    // Back-to-back with writeback stalled; pointers wrap here
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      issue(1'b1, 5'(i + 1), 6'(10 + i), 64'hA0 + 64'(i));
      #1;
      check("b2b_ready", {63'd0, issue_ready}, 64'd1);
    end
    tick();
    issue(1'b1, 5'd31, 6'd63, 64'hDEAD);
    #1;
    check("b2b_c4_ready", {63'd0, issue_ready}, 64'd0);
    check_wb("b2b_c4_head", 5'd1, 6'd10, 64'hA0);
    tick();
    tick();
    tick();
    check("b2b_c7_ready", {63'd0, issue_ready}, 64'd0);
    check_wb("b2b_c7_hold", 5'd1, 6'd10, 64'hA0);
    // Full credit: pop and issue_valid in the same cycle
    tick();
    wb_ready = 1'b1;
    #1;
    check("sim_c8_ready", {63'd0, issue_ready}, 64'd0);
    check_wb("drain0", 5'd1, 6'd10, 64'hA0);
    tick();
    idle();
    #1;
    check("sim_c9_ready", {63'd0, issue_ready}, 64'd1);
    check_wb("drain1", 5'd2, 6'd11, 64'hA1);
    tick();
    check_wb("drain2", 5'd3, 6'd12, 64'hA2);
    tick();
    check_wb("drain3", 5'd4, 6'd13, 64'hA3);
    tick();
    check("drain_end_wbv", {63'd0, wb_valid}, 64'd0);

    // Flush kills two in-flight ops and the op offered in the flush cycle
    tick();
    issue(1'b1, 5'd7, 6'd20, 64'h77);
    tick();
    issue(1'b1, 5'd8, 6'd21, 64'h88);
    tick();
    issue(1'b1, 5'd9, 6'd22, 64'h99);
    flush = 1'b1;
    #1;
    check("fl_c2_ready", {63'd0, issue_ready}, 64'd0);
    tick();
    flush = 1'b0;
    issue(1'b1, 5'd10, 6'd23, 64'hBEEF);
    #1;
    check("fl_c3_ready", {63'd0, issue_ready}, 64'd1);
    check("fl_c3_wbv", {63'd0, wb_valid}, 64'd0);
    for (int c = 4; c < 7; c++) begin
      tick();
      idle();
      #1;
      check("fl_dead_wbv", {63'd0, wb_valid}, 64'd0);
    end
    tick();
    check_wb("fl_c7", 5'd10, 6'd23, 64'hBEEF);
    tick();
    check("fl_c8_wbv", {63'd0, wb_valid}, 64'd0);

    // Reset mid-drain; three ops also confirm flush left credit at zero
    wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      issue(1'b1, 5'(i + 1), 6'(40 + i), 64'h100 + 64'(i));
      #1;
      check("rm_ready", {63'd0, issue_ready}, 64'd1);
    end
    tick();
    idle();
    repeat (3) tick();
    check_wb("rm_head", 5'd1, 6'd40, 64'h100);
    #1;
    rst = 1'b1;
    #1;
    check("rm_async_wbv", {63'd0, wb_valid}, 64'd0);
    check("rm_async_data", wb_data, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rm_rel_ready", {63'd0, issue_ready}, 64'd1);
    wb_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("rm_stale_wbv", {63'd0, wb_valid}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exu_mul_wb.md
EXU_MUL_WB -- requirements
Module: exu_mul_wb

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL be the width of the multiplier result and of wb_data.
REQ-002 Parameter REG_ADDR_WIDTH, default 5, SHALL be the width of the destination register index.
REQ-003 Parameter ROB_ID_WIDTH, default 6, SHALL be the width of the reorder-buffer tag.
REQ-004 Parameter DEPTH, default 4, SHALL be the result FIFO depth and the in-flight credit limit; the value is a power of two, at least 4.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-007 issue_valid  input  1  SHALL indicate that a multiply is issued to the 3-stage multiplier this cycle.
REQ-008 issue_ready  output  1  SHALL indicate that an issue is accepted this cycle.
REQ-009 issue_rd  input  REG_ADDR_WIDTH  SHALL give the destination register of the issued op.
REQ-010 issue_rob_id  input  ROB_ID_WIDTH  SHALL give the ROB tag of the issued op.
REQ-011 flush  input  1  SHALL kill all in-flight and buffered ops.
REQ-012 mul_result  input  DATA_WIDTH  SHALL carry the multiplier output, valid 3 cycles after issue.
REQ-013 wb_valid  output  1  SHALL indicate that a writeback is presented.
REQ-014 wb_ready  input  1  SHALL indicate that the writeback port accepts the op.
REQ-015 wb_rd  output  REG_ADDR_WIDTH  SHALL carry the writeback destination.
REQ-016 wb_rob_id  output  ROB_ID_WIDTH  SHALL carry the writeback ROB tag.
REQ-017 wb_data  output  DATA_WIDTH  SHALL carry the writeback data.

Function
REQ-018 An issue SHALL be accepted when issue_valid & issue_ready & ~flush.
REQ-019 The block SHALL keep a 3-stage shadow pipeline (valid, rd, rob_id) aligned with the multiplier: an op accepted in cycle N sits in stage 3 in cycle N+3.
REQ-020 When stage-3 valid is set in cycle N+3, the block SHALL push {rd, rob_id, mul_result} into the FIFO at the end of that cycle.
REQ-021 wb_valid/wb_rd/wb_rob_id/wb_data SHALL be driven from the FIFO head, registered; with an empty FIFO and wb_ready high, issue in cycle N gives wb_valid in cycle N+4.
REQ-022 A pop SHALL occur on wb_valid & wb_ready; push and pop in the same cycle SHALL both take effect, occupancy unchanged, order preserved.
REQ-023 While wb_valid is high and wb_ready is low, all wb_* outputs SHALL hold stable.
REQ-024 A credit counter (0..DEPTH) SHALL increment on accepted issue and decrement on pop; simultaneous accept and pop SHALL leave it unchanged.
REQ-025 issue_ready SHALL be (credit < DEPTH) & ~flush, so the non-stallable multiplier never overflows the FIFO.
REQ-026 Results SHALL leave in issue order; FIFO pointers SHALL wrap modulo DEPTH.
REQ-027 flush SHALL, at the clock edge, clear all shadow valids, empty the FIFO, and zero the credit counter; an issue in the flush cycle SHALL be dropped; multiplier outputs for killed ops SHALL be ignored.
REQ-028 wb_valid SHALL be low in the cycle after flush.
REQ-029 Push into a full FIFO SHALL be impossible by construction; an assertion SHALL flag it.

Reset
REQ-030 On rst asserted: shadow valids 0, FIFO empty, credit 0, wb_valid 0, wb_rd/wb_rob_id/wb_data 0, issue_ready 1 after release.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight ops immediately, without waiting for a clock edge.

Verification
REQ-032 Single op: issue rd=5 rob=3 in cycle 0, mul_result=0x1234 in cycle 3, wb_ready=1 -> wb_valid in cycle 4 with rd=5, rob=3, data=0x1234, for one cycle.
REQ-033 Back-to-back: issue 4 ops in cycles 0-3 with wb_ready=0 -> issue_ready=0 in cycle 4; FIFO full at cycle 7; raising wb_ready drains the 4 ops in order, one per cycle.
REQ-034 Simultaneous: credit=DEPTH with pop and issue_valid in the same cycle -> issue_ready=0 (credit not yet freed); next cycle issue_ready=1.
REQ-035 Flush: issue ops in cycles 0-1, flush in cycle 2 -> no wb_valid ever for those ops; credit=0; a new issue in cycle 3 writes back in cycle 7.
REQ-036 Reset mid-drain: 3 ops buffered, wb_valid=1, assert rst -> wb_valid=0 at once; after release issue_ready=1 and no stale op appears.
